// File: rtl/alu_dispatch.sv
// Initiator side of the 64-bit ALU interface: one op in flight, filters illegal opcodes and DIV by zero.
// Optional performance counters are compiled in when ALU_DISPATCH_PERF_EN is defined.

package alu_dispatch_pkg;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned OPC_W  = 8;
   localparam int unsigned ERR_W  = 2;
   localparam int unsigned PERF_W = 32;

   localparam logic [OPC_W-1:0] OPC_DIV  = OPC_W'(8'h04);
   localparam logic [OPC_W-1:0] OPC_LAST = OPC_W'(8'h0B);

   localparam logic [ERR_W-1:0] ERR_OK      = ERR_W'(2'b00);
   localparam logic [ERR_W-1:0] ERR_ILLEGAL = ERR_W'(2'b01);
   localparam logic [ERR_W-1:0] ERR_DIV0    = ERR_W'(2'b10);

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [DATA_W-1:0] operand1;
      logic [DATA_W-1:0] operand2;
   } alu_req_t;
endpackage

module alu_dispatch
   import alu_dispatch_pkg::*;
#(
   parameter int unsigned       TAG_W       = 5,
   parameter logic [DATA_W-1:0] DIV0_RESULT = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OPC_W-1:0]  req_opcode,
   input  logic [DATA_W-1:0] req_op1,
   input  logic [DATA_W-1:0] req_op2,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              alu_en,
   output logic [OPC_W-1:0]  alu_opcode,
   output logic [DATA_W-1:0] alu_operand1,
   output logic [DATA_W-1:0] alu_operand2,
   input  logic [DATA_W-1:0] alu_result,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_result,
   output logic [TAG_W-1:0]  resp_tag,
   output logic [ERR_W-1:0]  resp_err
`ifdef ALU_DISPATCH_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_issued,
   output logic [PERF_W-1:0] perf_stall
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              alu_en_q, alu_en_d;
   alu_req_t          alu_q, alu_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_result_q, resp_result_d;
   logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
   logic [ERR_W-1:0]  resp_err_q, resp_err_d;

   logic req_hs;
   logic req_illegal;
   logic req_div0;

   assign req_hs      = req_valid && req_ready_q;
   assign req_illegal = (req_opcode > OPC_LAST);
   assign req_div0    = (req_opcode == OPC_DIV) && (req_op2 == '0);

   // State register; reset discards any in-flight ALU result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         req_ready_q   <= 1'b0;
         alu_en_q      <= 1'b0;
         alu_q         <= '0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_tag_q    <= '0;
         resp_err_q    <= ERR_OK;
      end else begin
         state_q       <= state_d;
         req_ready_q   <= req_ready_d;
         alu_en_q      <= alu_en_d;
         alu_q         <= alu_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_tag_q    <= resp_tag_d;
         resp_err_q    <= resp_err_d;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      alu_d         = alu_q;
      resp_valid_d  = resp_valid_q;
      resp_result_d = resp_result_q;
      resp_tag_d    = resp_tag_q;
      resp_err_d    = resp_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_hs) begin
               resp_tag_d = req_tag;
               if (req_illegal) begin
                  resp_result_d = '0;
                  resp_err_d    = ERR_ILLEGAL;
                  resp_valid_d  = 1'b1;
                  state_d       = S_RESP;
               end else if (req_div0) begin
                  resp_result_d = DIV0_RESULT;
                  resp_err_d    = ERR_DIV0;
                  resp_valid_d  = 1'b1;
                  state_d       = S_RESP;
               end else begin
                  alu_d.opcode   = req_opcode;
                  alu_d.operand1 = req_op1;
                  alu_d.operand2 = req_op2;
                  state_d        = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // ALU result registered at the end of ISSUE is valid now.
            resp_result_d = alu_result;
            resp_err_d    = ERR_OK;
            resp_valid_d  = 1'b1;
            state_d       = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      alu_en_d    = (state_d == S_ISSUE);
      req_ready_d = (state_d == S_IDLE);
   end

   assign req_ready    = req_ready_q;
   assign alu_en       = alu_en_q;
   assign alu_opcode   = alu_q.opcode;
   assign alu_operand1 = alu_q.operand1;
   assign alu_operand2 = alu_q.operand2;
   assign resp_valid   = resp_valid_q;
   assign resp_result  = resp_result_q;
   assign resp_tag     = resp_tag_q;
   assign resp_err     = resp_err_q;

`ifdef ALU_DISPATCH_PERF_EN
   logic [PERF_W-1:0] perf_issued_q, perf_issued_d;
   logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

   // Free-running event counters, wrapping modulo 2^32.
   always_comb begin
      perf_issued_d = perf_issued_q;
      perf_stall_d  = perf_stall_q;
      if (alu_en_q) begin
         perf_issued_d = perf_issued_q + PERF_W'(1);
      end
      if (resp_valid_q && !resp_ready) begin
         perf_stall_d = perf_stall_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_issued = perf_issued_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
Initiator side of the 64-bit ALU interface. It takes one operation request at a time from decode over a valid/ready handshake and drives the ALU's en/opcode/operand1/operand2 for exactly one cycle. It captures the registered ALU result and returns it to writeback with the request tag over a valid/ready handshake. Illegal opcodes and divide-by-zero are filtered here and never reach the ALU.

Parameters:
TAG_W, 5, width of the destination tag carried from request to response.
DIV0_RESULT, 64'hFFFF_FFFF_FFFF_FFFF, result returned for DIV with operand2 == 0.

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  dispatcher can accept a request
req_opcode  input  8  ALU opcode
req_op1  input  64  operand 1
req_op2  input  64  operand 2
req_tag  input  TAG_W  destination tag
alu_en  output  1  ALU enable, one-cycle pulse per issue
alu_opcode  output  8  opcode to ALU
alu_operand1  output  64  operand 1 to ALU
alu_operand2  output  64  operand 2 to ALU
alu_result  input  64  ALU registered result
resp_valid  output  1  response present
resp_ready  input  1  writeback accepts response
resp_result  output  64  result
resp_tag  output  TAG_W  tag of the originating request
resp_err  output  2  00 ok, 01 illegal opcode, 10 divide-by-zero

Behaviour:
- Opcode map: ADD 0x00, ADDI 0x01, SUB 0x02, MUL 0x03, DIV 0x04, SLL 0x05, SRL 0x06, AND 0x07, OR 0x08, NOT 0x09, XOR 0x0A, LUI 0x0B. Any opcode >= 0x0C is illegal.
- All outputs are registered.
- Reset values: req_ready=0 during reset and 1 in the first cycle after; alu_en=0, alu_opcode=0, alu_operand1/2=0, resp_valid=0, resp_result=0, resp_tag=0, resp_err=0; state=IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- req_ready=1 only in IDLE. A handshake is req_valid && req_ready at a posedge.
- IDLE, on handshake: latch tag.
  - Illegal opcode: go to RESP with resp_result=0, resp_err=01; no ALU issue.
  - DIV with req_op2 == 0: go to RESP with resp_result=DIV0_RESULT, resp_err=10; no ALU issue.
  - Otherwise: drive alu_opcode/alu_operand1/alu_operand2 from the request, set alu_en=1, go to ISSUE.
- ISSUE (1 cycle): alu_en=1; the ALU samples at the end of this cycle. Next: alu_en=0, go to WAIT. Operands stay held.
- WAIT (1 cycle): alu_result is valid. At the end of the cycle, latch resp_result=alu_result, resp_err=00, and set resp_valid=1; go to RESP.
- RESP: resp_valid, resp_result, resp_tag and resp_err are held stable until resp_ready=1. On handshake: resp_valid=0, go to IDLE.
- Latency, handshake edge to resp_valid visible:
  - 3 cycles for issued ops.
  - 1 cycle for filtered ops (illegal opcode, divide-by-zero).
- Throughput: at most one op in flight. The next request is accepted no earlier than the cycle after the response handshake.
- alu_en is high for exactly one cycle per issued op and never high outside ISSUE.
- resp_ready asserted while resp_valid=0 is ignored.
- req_valid while not in IDLE is ignored; the request is not consumed.
- Reset asserted in any state: state returns to IDLE and alu_en drops at that edge. An in-flight ALU result is discarded and no response is produced for it.
- Operands pass through unmodified. Shift amount masking and LUI shifting are done by the ALU.

Optional Feature:
ALU_DISPATCH_PERF_EN. When defined, add output ports perf_issued[31:0] and perf_stall[31:0].
- perf_issued increments once per alu_en pulse.
- perf_stall increments each cycle with resp_valid=1 and resp_ready=0.
- Both counters clear on rst and wrap modulo 2^32.
When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ADD, op1=5, op2=7, tag=3, resp_ready=1: exactly one cycle of alu_en=1 with opcode 0x00. resp_valid rises 3 cycles after the handshake with resp_result=12, resp_tag=3, resp_err=00.
- DIV, op1=100, op2=0, tag=9: alu_en stays 0. resp_valid rises 1 cycle after the handshake with resp_result=64'hFFFF_FFFF_FFFF_FFFF, resp_err=10, resp_tag=9.
- Opcode 0x0C: no ALU issue; resp_result=0, resp_err=01.
- SUB, op1=10, op2=3, with resp_ready held 0 for 4 cycles: resp_valid and resp_result=7 hold stable. req_ready=0 throughout. A second req_valid is not accepted until one cycle after the response handshake.
- Reset asserted during ISSUE of MUL: alu_en=0 and state IDLE at the next edge. No resp_valid occurs. req_ready=1 in the first cycle after reset.
- With ALU_DISPATCH_PERF_EN: 3 issued ops plus 1 illegal op, and 2 cycles of resp_ready=0 → perf_issued=3, perf_stall=2.
